fcf_link_scheduler: RTL and testbench

Readout scheduler that shares one serial output line between two fast-cluster-finder channels. Each channel presents a 32-bit latched hit-location word qualified by a one-cycle data-valid strobe. The block buffers each channel's words in a small FIFO and grants the line round-robin. It emits each word as a framed bit stream clocked by the bunch-crossing clock. It sits downstream of the cluster-finder instances and upstream of the off-chip driver.

---
 rtl/fcf_link_scheduler.sv | 133 +++++++++++++
 tb/tb_fcf_link_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fcf_link_scheduler.sv
// fcf_link_scheduler: two-channel FIFO-buffered round-robin serial framer for cluster-finder hit words.
// Optional parity bit after the data bits when FCF_SCHED_PARITY_EN is defined.
module fcf_link_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        BCclk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        dataV0,
  input  logic [31:0] hit0,
  input  logic        dataV1,
  input  logic [31:0] hit1,
  output logic        serial_out,
  output logic        frame_start,
  output logic        busy,
  output logic        ovf0,
  output logic        ovf1
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, SRC, DATA, PAR} state_t;
  state_t      state_q, state_d;
  logic [AW:0] wp_q [2];
  logic [AW:0] wp_d [2];
  logic [AW:0] rp_q [2];
  logic [AW:0] rp_d [2];
  logic [31:0] mem_q [2][FIFO_DEPTH];
  logic [31:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        src_q, src_d, last_q, last_d;
  logic        out_q, out_d, fs_q, fs_d, busy_q, busy_d;
  logic [1:0]  ovf_q, ovf_d;
  logic [1:0]  dv, ne, full, pop, push;
  logic        sel;
  always_comb begin
    dv = {dataV1, dataV0};
    for (int c = 0; c < 2; c++) begin
      ne[c]   = wp_q[c] != rp_q[c];
      full[c] = (wp_q[c][AW] != rp_q[c][AW]) && (wp_q[c][AW-1:0] == rp_q[c][AW-1:0]);
    end
    sel = (ne[0] && ne[1]) ? ~last_q : ne[1];
    pop = (state_q == IDLE && enable && |ne) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    // A pop in the same cycle frees the slot a push to a full FIFO needs
    for (int c = 0; c < 2; c++) begin
      push[c]  = enable && dv[c] && (!full[c] || pop[c]);
      wp_d[c]  = enable ? wp_q[c] + (AW+1)'(push[c]) : '0;
      rp_d[c]  = enable ? rp_q[c] + (AW+1)'(pop[c]) : '0;
      ovf_d[c] = enable && (ovf_q[c] || (dv[c] && full[c] && !pop[c]));
    end
    state_d = IDLE;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    src_d   = src_q;
    last_d  = last_q;
    out_d   = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: if (|ne) begin
          state_d = START;
          sr_d    = mem_q[sel][rp_q[sel][AW-1:0]];
          src_d   = sel;
          last_d  = sel;
          out_d   = 1'b1;
          fs_d    = 1'b1;
          busy_d  = 1'b1;
        end
        START: begin
          state_d = SRC;
          out_d   = src_q;
          busy_d  = 1'b1;
        end
        SRC: begin
          state_d = DATA;
          cnt_d   = 5'd31;
          out_d   = sr_q[31];
          busy_d  = 1'b1;
        end
        DATA: if (cnt_q != 5'd0) begin
          state_d = DATA;
          cnt_d   = cnt_q - 5'd1;
          out_d   = sr_q[cnt_d];
          busy_d  = 1'b1;
        end else begin
`ifdef FCF_SCHED_PARITY_EN
          state_d = PAR;
          out_d   = ^{sr_q, src_q};
          busy_d  = 1'b1;
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge BCclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wp_q    <= '{default: '0};
      rp_q    <= '{default: '0};
      sr_q    <= '0;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      out_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      last_q  <= last_d;
      out_q   <= out_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end
  always_ff @(posedge BCclk) begin
    for (int c = 0; c < 2; c++)
      if (push[c]) mem_q[c][wp_q[c][AW-1:0]] <= (c == 1) ? hit1 : hit0;
  end
  assign serial_out  = out_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign ovf0        = ovf_q[0];
  assign ovf1        = ovf_q[1];
endmodule

// File: tb/tb_fcf_link_scheduler.sv
// tb_fcf_link_scheduler: vector table, directed corner sequences and random traffic against a frame-queue model.
// Honours FCF_SCHED_PARITY_EN to match the build of the design.
module tb_fcf_link_scheduler;
  localparam int D = 4;
  logic        BCclk = 1'b0, reset_n = 1'b0, enable = 1'b0, dataV0 = 1'b0, dataV1 = 1'b0;
  logic [31:0] hit0 = '0, hit1 = '0;
  logic        serial_out, frame_start, busy, ovf0, ovf1;
  int          checks = 0, errors = 0;

  fcf_link_scheduler #(.FIFO_DEPTH(D)) dut (
    .BCclk(BCclk), .reset_n(reset_n), .enable(enable),
    .dataV0(dataV0), .hit0(hit0), .dataV1(dataV1), .hit1(hit1),
    .serial_out(serial_out), .frame_start(frame_start), .busy(busy),
    .ovf0(ovf0), .ovf1(ovf1)
  );

  always #5 BCclk = ~BCclk;

  // Model: word queues per channel and a queue of line symbols (0/1 frame bits, 2 = idle gap)
  logic [31:0] q0[$], q1[$];
  int          fb[$];
  logic        m_last, m_out, m_fs, m_busy;
  logic [1:0]  m_ovf;

  typedef struct {
    logic        en, dv0, dv1;
    logic [31:0] h0, h1;
    logic [4:0]  exp;
  } vec_t;
  vec_t tbl[37];

  function automatic logic [4:0] outs();
    return {serial_out, frame_start, busy, ovf1, ovf0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    q0.delete(); q1.delete(); fb.delete();
    m_last = 1'b1; m_ovf = '0; m_out = 0; m_fs = 0; m_busy = 0;
  endfunction

  function automatic void m_edge();
    logic [31:0] w;
    int ch, v;
    m_fs = 0; m_out = 0; m_busy = 0;
    if (!enable) begin
      q0.delete(); q1.delete(); fb.delete(); m_ovf = '0;
      return;
    end
    if (fb.size() == 0 && (q0.size() > 0 || q1.size() > 0)) begin
      ch = (q0.size() > 0 && q1.size() > 0) ? (m_last ? 0 : 1) : (q0.size() > 0 ? 0 : 1);
      w = (ch == 0) ? q0.pop_front() : q1.pop_front();
      m_last = (ch == 1);
      fb.push_back(1);
      fb.push_back(ch);
      for (int i = 31; i >= 0; i--) fb.push_back(int'(w[i]));
`ifdef FCF_SCHED_PARITY_EN
      fb.push_back(int'(^w) ^ ch);
`endif
      fb.push_back(2);
      m_fs = 1;
    end
    if (dataV0) begin
      if (q0.size() < D) q0.push_back(hit0); else m_ovf[0] = 1'b1;
    end
    if (dataV1) begin
      if (q1.size() < D) q1.push_back(hit1); else m_ovf[1] = 1'b1;
    end
    if (fb.size() > 0) begin
      v = fb.pop_front();
      m_out = (v == 1);
      m_busy = (v != 2);
    end
  endfunction

  task automatic step();
    m_edge();
    @(posedge BCclk);
    #1;
    check("cycle", outs(), {m_out, m_fs, m_busy, m_ovf[1], m_ovf[0]});
  endtask

  task automatic do_reset();
    enable = 0; dataV0 = 0; dataV1 = 0;
    #2 reset_n = 0;
    #1 check("areset", outs(), 5'b0);
    m_reset();
    @(posedge BCclk);
    #1 reset_n = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] pat;
    int cnt;
    int rate;
    pat = 32'b1010_0101_1010_0101_0000_1111_0000_1111;
    for (int i = 0; i < 37; i++) tbl[i] = '{en: 1, dv0: 0, dv1: 0, h0: 0, h1: 0, exp: 5'b0};
    tbl[0].dv0 = 1;
    tbl[0].h0 = 32'hA5A5_0F0F;
    tbl[1].exp = 5'b11100;
    tbl[2].exp = 5'b00100;
    for (int i = 3; i <= 34; i++) tbl[i].exp = {pat[34-i], 4'b0100};
`ifdef FCF_SCHED_PARITY_EN
    tbl[35].exp = 5'b00100;
`endif

    m_reset();
    do_reset();

    // Single word from the vector table
    for (int i = 0; i < 37; i++) begin
      enable = tbl[i].en; dataV0 = tbl[i].dv0; dataV1 = tbl[i].dv1;
      hit0 = tbl[i].h0; hit1 = tbl[i].h1;
      step();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Round-robin: simultaneous pushes, channel 0 first, channel 1 35 cycles later
    do_reset();
    enable = 1; dataV0 = 1; dataV1 = 1; hit0 = 32'h1; hit1 = 32'h2;
    step();
    dataV0 = 0; dataV1 = 0;
    for (int k = 1; k <= 37; k++) begin
      step();
      if (k == 1) check("rr_fs0", frame_start, 1);
      if (k == 2) check("rr_src0", serial_out, 0);
      if (k == 34) check("rr_lsb0", serial_out, 1);
      if (k == 36) check("rr_fs1", frame_start, 1);
      if (k == 37) check("rr_src1", serial_out, 1);
    end
    idle(40);

    // Overflow: six consecutive pushes into a depth-4 FIFO
    do_reset();
    enable = 1;
    for (int k = 0; k < 6; k++) begin
      dataV0 = 1; hit0 = 32'h100 + k;
      step();
      if (k == 1) check("ovf_pop_e1", frame_start, 1);
      if (k == 4) check("ovf_not_yet", ovf0, 0);
      if (k == 5) check("ovf_set", ovf0, 1);
    end
    dataV0 = 0;
    cnt = 0;
    for (int k = 0; k < 5 * 35 + 10; k++) begin
      step();
      if (frame_start) cnt++;
    end
    check("ovf_frames", cnt, 4);

    // Disable during data bit 20, with ovf1 already set
    do_reset();
    enable = 1;
    for (int k = 0; k <= 14; k++) begin
      dataV0 = (k == 0); hit0 = 32'hFFFF_FFFF;
      dataV1 = (k < 5); hit1 = 32'h10 + k;
      step();
      if (k == 4) check("dis_ovf1", ovf1, 1);
    end
    dataV0 = 0; dataV1 = 0;
    check("dis_bit20", {serial_out, busy}, 2'b11);
    enable = 0;
    step();
    check("dis_clear", outs(), 5'b0);
    enable = 1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (busy) cnt++;
    end
    check("dis_no_frames", cnt, 0);

    // Async reset mid-frame after channel 0 was served
    do_reset();
    enable = 1; dataV0 = 1; dataV1 = 1; hit0 = 32'h3; hit1 = 32'h4;
    step();
    dataV0 = 0; dataV1 = 0;
    idle(10);
    do_reset();
    enable = 1; dataV0 = 1; dataV1 = 1; hit0 = 32'h5; hit1 = 32'h6;
    step();
    dataV0 = 0; dataV1 = 0;
    step();
    check("ar_fs", frame_start, 1);
    step();
    check("ar_src0", serial_out, 0);
    idle(75);

`ifdef FCF_SCHED_PARITY_EN
    do_reset();
    enable = 1; dataV1 = 1; hit1 = 32'h0000_0007;
    step();
    dataV1 = 0;
    for (int k = 1; k <= 37; k++) begin
      step();
      if (k == 2) check("par_src1", serial_out, 1);
      if (k == 35) check("par_bit", {serial_out, busy}, 2'b01);
      if (k == 36) check("par_gap", {serial_out, busy}, 2'b00);
    end
`endif

    // Random traffic alternating light and bursty phases
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rate = ((c / 500) % 2 == 1) ? 3 : 45;
      enable = ($urandom_range(0, 299) != 0);
      dataV0 = ($urandom_range(0, rate) == 0); hit0 = $urandom;
      dataV1 = ($urandom_range(0, rate) == 0); hit1 = $urandom;
      step();
    end
    enable = 1; dataV0 = 0; dataV1 = 0;
    idle(40 * 2 * D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
